// File: rtl/fifo_uart_drain.sv
// rtl/fifo_uart_drain.sv - pops words from a synchronous FIFO and serialises them UART-style on tx_out
// Line output is registered from the current state, so the line lags the FSM by one cycle.
module fifo_uart_drain #(
    parameter int DT_WIDTH     = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_en,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [DT_WIDTH-1:0]  fifo_rd_dt,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 frame_done,
    output logic [CNT_WIDTH-1:0] frame_cnt
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DT_WIDTH > 1) ? $clog2(DT_WIDTH) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DT_WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [TW-1:0]       tick_cnt;
    logic [BW-1:0]       bit_cnt;
    logic [DT_WIDTH-1:0] shreg;
    logic                tick_last;
    logic                tx_nxt;
    logic                done_nxt;

    assign tick_last  = (tick_cnt == TICK_LAST);
    assign fifo_rd_en = (state == S_FETCH);
    assign busy       = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        tx_nxt    = 1'b1;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (tx_en && !fifo_empty) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_START;
            S_START: begin
                tx_nxt = 1'b0;
                if (tick_last) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                tx_nxt = shreg[0];
                if (tick_last && (bit_cnt == DATA_LAST)) begin
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                // fifo_empty only matters here and in IDLE, so an empty FIFO is never read
                if (tick_last && (bit_cnt == STOP_LAST)) begin
                    done_nxt  = 1'b1;
                    state_nxt = (tx_en && !fifo_empty) ? S_FETCH : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            tx_out     <= 1'b1;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            tx_out     <= tx_nxt;
            frame_done <= done_nxt;
            if (done_nxt) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
        end else if (state == S_LOAD) begin
            shreg <= fifo_rd_dt;
        end else if ((state == S_DATA) && tick_last) begin
            shreg <= shreg >> 1;
        end
    end

    // Bit counter indexes data bits in DATA and stop bits in STOP; any state change clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (state inside {S_START, S_DATA, S_STOP}) begin
                tick_cnt <= tick_last ? '0 : tick_cnt + 1'b1;
            end else begin
                tick_cnt <= '0;
            end
            if (state != state_nxt) begin
                bit_cnt <= '0;
            end else if (tick_last && (state inside {S_DATA, S_STOP})) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// tb/tb_fifo_uart_drain.sv - self-checking bench for fifo_uart_drain with FIFO and line models
module tb_fifo_uart_drain;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_en = 1'b0;
    logic sel = 1'b0;
    always #5 clk = ~clk;

    logic fe1, fe2, rd1, rd2, tx1, tx2, busy1, busy2, fd1, fd2;
    logic [7:0]  dt1 = 8'h00;
    logic [7:0]  dt2 = 8'h00;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;

    logic [7:0] mem1 [512];
    logic [7:0] mem2 [512];
    int np1 = 0, nr1 = 0, np2 = 0, nr2 = 0;
    int erd1 = 0, erd2 = 0, rdc1 = 0, rdc2 = 0;

    assign fe1 = (np1 == nr1);
    assign fe2 = (np2 == nr2);

    fifo_uart_drain #(.DT_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fe1), .fifo_rd_en(rd1),
        .fifo_rd_dt(dt1), .tx_out(tx1), .busy(busy1), .frame_done(fd1), .frame_cnt(cnt1)
    );

    fifo_uart_drain #(.DT_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fe2), .fifo_rd_en(rd2),
        .fifo_rd_dt(dt2), .tx_out(tx2), .busy(busy2), .frame_done(fd2), .frame_cnt(cnt2)
    );

    // Upstream FIFO models: one-cycle read latency, empty flag updates at the read edge
    always @(posedge clk) begin
        if (rd1) begin
            rdc1 <= rdc1 + 1;
            if (np1 == nr1) erd1 <= erd1 + 1;
            else begin
                dt1 <= mem1[nr1 % 512];
                nr1 <= nr1 + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (rd2) begin
            rdc2 <= rdc2 + 1;
            if (np2 == nr2) erd2 <= erd2 + 1;
            else begin
                dt2 <= mem2[nr2 % 512];
                nr2 <= nr2 + 1;
            end
        end
    end

    logic        tx_m, busy_m, fd_m;
    logic [15:0] cnt_m;
    assign tx_m   = sel ? tx2 : tx1;
    assign busy_m = sel ? busy2 : busy1;
    assign fd_m   = sel ? fd2 : fd1;
    assign cnt_m  = sel ? {14'b0, cnt2} : cnt1;

    typedef struct {
        logic [7:0]  dt;
        logic [11:0] line;
        int          gap;
    } vec_t;

    vec_t       tbl [4];
    logic [7:0] exp_q [$];
    int         model_cnt [2];
    int         nstop = 1;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        if (!sel) begin
            mem1[np1 % 512] = b;
            np1++;
        end else begin
            mem2[np2 % 512] = b;
            np2++;
        end
    endtask

    // Line levels per bit slot: start low, data LSB first, then stop bits high
    function automatic logic [11:0] model_line(input logic [7:0] b);
        logic [11:0] v;
        v    = '1;
        v[0] = 1'b0;
        for (int i = 0; i < 8; i++) v[i+1] = b[i];
        return v;
    endfunction

    task automatic wait_start(output int highs);
        bit found;
        found = 0;
        highs = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (tx_m === 1'b0) found = 1;
            else highs++;
        end
        if (!found) chk("start_timeout", 0, 1);
    endtask

    task automatic run_frame(input logic [11:0] line, input int drop_at);
        int len, bad, dbad, bbad, slot;
        len  = (9 + nstop) * CPB;
        bad  = 0;
        dbad = 0;
        bbad = 0;
        for (int c = 0; c < len; c++) begin
            if (c > 0) @(negedge clk);
            if (c == drop_at) tx_en = 1'b0;
            slot = c / CPB;
            if (tx_m !== line[slot]) bad++;
            if (fd_m !== (c == len - 1)) dbad++;
            if ((c < len - 1) && (busy_m !== 1'b1)) bbad++;
        end
        model_cnt[sel]++;
        chk("line_bits", bad, 0);
        chk("frame_done", dbad, 0);
        chk("busy_in_frame", bbad, 0);
        chk("frame_cnt", int'(cnt_m), model_cnt[sel] % (sel ? 4 : 65536));
    endtask

    initial begin
        int h, v0, v1, v2, v3, rd0, n;
        logic [7:0] b;

        model_cnt[0] = 0;
        model_cnt[1] = 0;
        tbl[0] = '{dt: 8'hA5, line: 12'h34A, gap: 3};
        tbl[1] = '{dt: 8'h00, line: 12'h200, gap: 3};
        tbl[2] = '{dt: 8'hFF, line: 12'h3FE, gap: 2};
        tbl[3] = '{dt: 8'h3C, line: 12'h278, gap: 2};

        repeat (3) @(negedge clk);
        chk("rst_tx_out", int'(tx1), 1);
        chk("rst_rd_en", int'(rd1), 0);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_frame_done", int'(fd1), 0);
        chk("rst_frame_cnt", int'(cnt1), 0);

        // Empty FIFO with tx_en high: nothing may happen
        rst = 1'b0;
        tx_en = 1'b1;
        v0 = 0; v1 = 0; v2 = 0; v3 = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx1 !== 1'b1) v0++;
            if (rd1 !== 1'b0) v1++;
            if (busy1 !== 1'b0) v2++;
            if (cnt1 !== 16'd0) v3++;
        end
        chk("idle_tx_out", v0, 0);
        chk("idle_rd_en", v1, 0);
        chk("idle_busy", v2, 0);
        chk("idle_frame_cnt", v3, 0);

        // Table vectors: single frame from idle, then three back-to-back
        rd0 = rdc1;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) push(tbl[0].dt);
            if (i == 1) begin
                repeat (5) @(negedge clk);
                push(tbl[1].dt);
                push(tbl[2].dt);
                push(tbl[3].dt);
            end
            wait_start(h);
            chk("start_gap", h, tbl[i].gap);
            run_frame(tbl[i].line, -1);
            if (i == 0) chk("rd_pulses_single", rdc1 - rd0, 1);
        end
        chk("rd_pulses_total", rdc1 - rd0, 4);

        // tx_en dropped mid-DATA: frame completes, second word waits
        repeat (3) @(negedge clk);
        push(8'h5A);
        push(8'hC3);
        wait_start(h);
        run_frame(model_line(8'h5A), 13);
        v0 = 0;
        repeat (30) begin
            @(negedge clk);
            if ((tx1 !== 1'b1) || (busy1 !== 1'b0)) v0++;
        end
        chk("held_idle", v0, 0);
        chk("word_kept", np1 - nr1, 1);
        tx_en = 1'b1;
        wait_start(h);
        chk("resume_gap", h, 3);
        run_frame(model_line(8'hC3), -1);

        // Async reset during DATA bit 3 aborts the frame and loses the popped word
        repeat (3) @(negedge clk);
        push(8'h96);
        push(8'h69);
        wait_start(h);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_tx_out", int'(tx1), 1);
        chk("abort_busy", int'(busy1), 0);
        chk("abort_frame_cnt", int'(cnt1), 0);
        model_cnt[0] = 0;
        model_cnt[1] = 0;
        @(negedge clk);
        rst = 1'b0;
        wait_start(h);
        chk("post_rst_gap", h, 3);
        run_frame(model_line(8'h69), -1);
        chk("fifo_drained", np1 - nr1, 0);

        // Random bursts against the queue scoreboard
        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                push(b);
                exp_q.push_back(b);
            end
            for (int j = 0; j < n; j++) begin
                wait_start(h);
                chk("rand_gap", h, (j == 0) ? 3 : 2);
                b = exp_q.pop_front();
                run_frame(model_line(b), -1);
            end
            repeat ($urandom_range(0, 10)) @(negedge clk);
        end

        // Two stop bits and a 2-bit wrapping frame counter
        sel = 1'b1;
        nstop = 2;
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            b = 8'($urandom);
            push(b);
            exp_q.push_back(b);
        end
        for (int j = 0; j < 5; j++) begin
            wait_start(h);
            chk("stop2_gap", h, (j == 0) ? 3 : 2);
            b = exp_q.pop_front();
            run_frame(model_line(b), -1);
        end
        chk("rd_pulses_dut2", rdc2, 5);
        chk("empty_reads", erd1 + erd2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
